// File: rtl/rocket_alloc_pkg.sv
// Shared types and default sizing for the rocket slot allocator.
package rocket_alloc_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LAUNCH = 2'd1,
        FLYING = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } side_state_t;

    localparam int unsigned P_SLOTS_DFLT    = 2;
    localparam int unsigned A_SLOTS_DFLT    = 3;
    localparam int unsigned P_COOLDOWN_DFLT = 8;
    localparam int unsigned A_COOLDOWN_DFLT = 16;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned STAT_W          = 16;

endpackage

// File: rtl/rocket_slot_pool.sv
// One side's rocket slots: slot FSMs, request/cooldown FSM and free-slot picker.
// Optional grant/drop statistics when ROCKET_ALLOC_STATS_EN is defined.
module rocket_slot_pool #(
    parameter int unsigned N           = 2,
    parameter int unsigned COOLDOWN    = 8,
    parameter bit          ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         start_of_frame,
    input  logic         game_mode,
    input  logic         fire_req,
    input  logic [N-1:0] done,
    output logic [N-1:0] launch,
    output logic [N-1:0] active,
    output logic         busy
`ifdef ROCKET_ALLOC_STATS_EN
    ,
    output logic [rocket_alloc_pkg::STAT_W-1:0] grant_cnt,
    output logic [rocket_alloc_pkg::STAT_W-1:0] drop_cnt
`endif
);
    import rocket_alloc_pkg::*;

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    slot_state_t      slot_q [N];
    slot_state_t      slot_d [N];
    side_state_t      side_q, side_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d, pick_idx;
    logic             pick_found, grant;
    logic [N-1:0]     launch_q, launch_d, active_q, active_d;
    logic             busy_q, busy_d;

    // Free-slot search: fixed from index 0, or rotating from one past the last grant.
    always_comb begin
        int unsigned j;
        j          = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = ROUND_ROBIN ? (32'(last_q) + 32'd1 + k) % N : k;
            if (!pick_found && slot_q[IDX_W'(j)] == FREE) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        side_d = side_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        grant  = 1'b0;

        for (int unsigned k = 0; k < N; k++) begin
            case (slot_q[k])
                LAUNCH:  slot_d[k] = FLYING;
                FLYING:  if (done[k]) slot_d[k] = FREE;
                default: ;
            endcase
        end

        // Decisions use the registered slot state, so a slot freed by done waits a cycle.
        case (side_q)
            IDLE: begin
                if (fire_req) begin
                    if (pick_found) grant = 1'b1;
                    else            side_d = PENDING;
                end
            end
            PENDING: grant = pick_found;
            rocket_alloc_pkg::COOLDOWN: begin
                if (cnt_q == '0) begin
                    side_d = IDLE;
                end else if (start_of_frame) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) side_d = IDLE;
                end
            end
            default: side_d = IDLE;
        endcase

        if (grant) begin
            side_d = rocket_alloc_pkg::COOLDOWN;
            cnt_d  = CNT_W'(COOLDOWN);
            last_d = pick_idx;
            for (int unsigned k = 0; k < N; k++) begin
                if (pick_idx == IDX_W'(k)) slot_d[k] = LAUNCH;
            end
        end

        if (!game_mode) begin
            for (int unsigned k = 0; k < N; k++) slot_d[k] = FREE;
            side_d = IDLE;
            cnt_d  = '0;
            last_d = IDX_W'(N - 1);
            grant  = 1'b0;
        end

        for (int unsigned k = 0; k < N; k++) begin
            launch_d[k] = (slot_d[k] == LAUNCH);
            active_d[k] = (slot_d[k] != FREE);
        end
        busy_d = (side_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned k = 0; k < N; k++) slot_q[k] <= FREE;
            side_q   <= IDLE;
            cnt_q    <= '0;
            last_q   <= IDX_W'(N - 1);
            launch_q <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            side_q   <= side_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            launch_q <= launch_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    assign launch = launch_q;
    assign active = active_q;
    assign busy   = busy_q;

`ifdef ROCKET_ALLOC_STATS_EN
    logic              drop_c;
    logic [STAT_W-1:0] grant_cnt_q, drop_cnt_q;

    assign drop_c = game_mode && fire_req && (side_q != IDLE);

    // Saturating statistics, cleared only by the hardware reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            grant_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (grant && grant_cnt_q != '1) grant_cnt_q <= grant_cnt_q + STAT_W'(1);
            if (drop_c && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + STAT_W'(1);
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: rtl/rocket_slot_allocator.sv
// Rocket slot scheduler: lowest-index player slots, round-robin alien slots, per-side cooldown.
// Define ROCKET_ALLOC_STATS_EN to add grant/drop statistic outputs.
module rocket_slot_allocator
    import rocket_alloc_pkg::*;
#(
    parameter int unsigned P_SLOTS    = P_SLOTS_DFLT,
    parameter int unsigned A_SLOTS    = A_SLOTS_DFLT,
    parameter int unsigned P_COOLDOWN = P_COOLDOWN_DFLT,
    parameter int unsigned A_COOLDOWN = A_COOLDOWN_DFLT
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               isGameMode,
    input  logic               p_fire_req,
    input  logic               a_fire_req,
    input  logic [P_SLOTS-1:0] p_done,
    input  logic [A_SLOTS-1:0] a_done,
    output logic [P_SLOTS-1:0] p_launch,
    output logic [A_SLOTS-1:0] a_launch,
    output logic [P_SLOTS-1:0] p_active,
    output logic [A_SLOTS-1:0] a_active,
    output logic               p_busy
`ifdef ROCKET_ALLOC_STATS_EN
    ,
    output logic [STAT_W-1:0]  p_grant_cnt,
    output logic [STAT_W-1:0]  p_drop_cnt,
    output logic [STAT_W-1:0]  a_grant_cnt,
    output logic [STAT_W-1:0]  a_drop_cnt
`endif
);

    rocket_slot_pool #(
        .N           (P_SLOTS),
        .COOLDOWN    (P_COOLDOWN),
        .ROUND_ROBIN (1'b0)
    ) u_player (
        .clk            (clk),
        .resetN         (resetN),
        .start_of_frame (startOfFrame),
        .game_mode      (isGameMode),
        .fire_req       (p_fire_req),
        .done           (p_done),
        .launch         (p_launch),
        .active         (p_active),
        .busy           (p_busy)
`ifdef ROCKET_ALLOC_STATS_EN
        ,
        .grant_cnt      (p_grant_cnt),
        .drop_cnt       (p_drop_cnt)
`endif
    );

    // Alien side has no busy port; its busy flag is left open.
    rocket_slot_pool #(
        .N           (A_SLOTS),
        .COOLDOWN    (A_COOLDOWN),
        .ROUND_ROBIN (1'b1)
    ) u_alien (
        .clk            (clk),
        .resetN         (resetN),
        .start_of_frame (startOfFrame),
        .game_mode      (isGameMode),
        .fire_req       (a_fire_req),
        .done           (a_done),
        .launch         (a_launch),
        .active         (a_active),
        .busy           ()
`ifdef ROCKET_ALLOC_STATS_EN
        ,
        .grant_cnt      (a_grant_cnt),
        .drop_cnt       (a_drop_cnt)
`endif
    );

endmodule
